// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one external 16-bit SRAM between the CPU memory port
// and a debug/loader port; each access runs IDLE -> SETUP -> ACCESS -> DONE.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] dbg_rdata,
  output logic        dbg_ack,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] Data_to_SRAM,
  output logic [19:0] ADDR,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        grant,
  output logic        busy
);

  localparam int WEFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = (WEFF > 1) ? $clog2(WEFF) : 1;
  localparam logic [CW-1:0] CTR_LOAD = CW'(WEFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   ctr_q;
  logic            we_q;
  logic [15:0]     wdata_q;
  logic            last_q;
  logic            grant_q;
  logic            busy_q;
  logic [19:0]     addr_q;
  logic [15:0]     dto_q;
  logic [15:0]     cpu_rdata_q;
  logic [15:0]     dbg_rdata_q;
  logic            cpu_ack_q;
  logic            dbg_ack_q;
  logic            ce_q;
  logic            oe_q;
  logic            wen_q;
  logic            ub_q;
  logic            lb_q;
  logic            sel_dbg;

  // On a tie the requester that was not served last wins.
  assign sel_dbg = (cpu_req && dbg_req) ? ~last_q : dbg_req;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      ctr_q       <= {CW{1'b0}};
      we_q        <= 1'b0;
      wdata_q     <= 16'h0000;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= 20'h00000;
      dto_q       <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
      dbg_rdata_q <= 16'h0000;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      wen_q       <= 1'b1;
      ub_q        <= 1'b1;
      lb_q        <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            grant_q <= sel_dbg;
            we_q    <= sel_dbg ? dbg_we : cpu_we;
            wdata_q <= sel_dbg ? dbg_wdata : cpu_wdata;
            addr_q  <= {4'b0000, (sel_dbg ? dbg_addr : cpu_addr)};
            ce_q    <= 1'b0;
            ub_q    <= 1'b0;
            lb_q    <= 1'b0;
            oe_q    <= 1'b1;
            wen_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          ctr_q   <= CTR_LOAD;
          state_q <= ACCESS;
          if (we_q) begin
            wen_q <= 1'b0;
            dto_q <= wdata_q;
          end else begin
            oe_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (ctr_q == {CW{1'b0}}) begin
            oe_q    <= 1'b1;
            wen_q   <= 1'b1;
            state_q <= DONE;
            if (grant_q) begin
              dbg_ack_q <= 1'b1;
              if (!we_q) begin
                dbg_rdata_q <= Data_from_SRAM;
              end
            end else begin
              cpu_ack_q <= 1'b1;
              if (!we_q) begin
                cpu_rdata_q <= Data_from_SRAM;
              end
            end
          end else begin
            ctr_q <= ctr_q - CW'(1);
          end
        end
        DONE: begin
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          last_q    <= grant_q;
          ce_q      <= 1'b1;
          ub_q      <= 1'b1;
          lb_q      <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_ack      = cpu_ack_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign dbg_ack      = dbg_ack_q;
  assign Data_to_SRAM = dto_q;
  assign ADDR         = addr_q;
  assign Mem_CE       = ce_q;
  assign Mem_OE       = oe_q;
  assign Mem_WE       = wen_q;
  assign Mem_UB       = ub_q;
  assign Mem_LB       = lb_q;
  assign grant        = grant_q;
  assign busy         = busy_q;

endmodule
